sprite_rom_arbiter: RTL and testbench

Shares one synchronous image-ROM read port between several sprite drawers (gloves, ball, goalkeeper overlays) in the VGA pixel pipeline. Requesters present an address with a request strobe. The arbiter grants one requester per cycle by round-robin and issues the ROM read. It then returns the pixel data tagged to the granted requester after a fixed, known latency, so each drawer can size its sync/blank delay line accordingly.

---
 rtl/sprite_rom_arbiter.sv | 110 +++++++++++
 tb/tb_sprite_rom_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous image-ROM read port between sprite drawers.
// Returns pixel data tagged with the requester id after a fixed RD_LAT+2 cycle latency.
module sprite_rom_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 20,
    parameter int DATA_W = 12,
    parameter int RD_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    output logic [NREQ-1:0]          gnt,
    output logic                     rom_en,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [DATA_W-1:0]        rom_data,
    output logic [NREQ-1:0]          rd_valid,
    output logic [DATA_W-1:0]        rd_data
);

    localparam int PTR_W = (NREQ > 2) ? 2 : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);

    // Wrap by explicit compare so non-power-of-two NREQ works.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? PTR_ZERO : p + PTR_W'(1);
    endfunction

    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic [PTR_W-1:0]             win_s, scan_s;
    logic                         hit_s, grant_s;
    logic                         rom_en_q, rom_en_d;
    logic [ADDR_W-1:0]            rom_addr_q, rom_addr_d;
    logic [RD_LAT:0]              tag_v_q, tag_v_d;
    logic [RD_LAT:0][NREQ-1:0]    tag_id_q, tag_id_d;
    logic [NREQ-1:0]              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]            rd_data_q, rd_data_d;

    // Round-robin search starting at the priority pointer.
    always_comb begin
        hit_s  = 1'b0;
        win_s  = ptr_q;
        scan_s = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            win_s  = (!hit_s && req[scan_s]) ? scan_s : win_s;
            hit_s  = hit_s | req[scan_s];
            scan_s = ptr_inc(scan_s);
        end
    end

    assign grant_s = hit_s & ~rst;
    assign gnt     = grant_s ? (ONE_HOT0 << win_s) : {NREQ{1'b0}};

    // Next-state for pointer, ROM issue, tag pipeline and return stage.
    always_comb begin
        ptr_d = ptr_q;
        if (frame_start) begin
            ptr_d = PTR_ZERO;
        end else if (grant_s) begin
            ptr_d = ptr_inc(win_s);
        end else begin
            ptr_d = ptr_q;
        end

        rom_en_d   = grant_s;
        rom_addr_d = grant_s ? req_addr[int'(win_s)*ADDR_W +: ADDR_W] : rom_addr_q;

        // Tag travels with the read; slot RD_LAT lines up with valid rom_data.
        tag_v_d  = {tag_v_q[RD_LAT-1:0], grant_s};
        tag_id_d = {tag_id_q[RD_LAT-1:0], gnt};

        if (tag_v_q[RD_LAT]) begin
            rd_valid_d = tag_id_q[RD_LAT];
            rd_data_d  = rom_data;
        end else begin
            rd_valid_d = {NREQ{1'b0}};
            rd_data_d  = rd_data_q;
        end
    end

    // State registers; reset discards every in-flight tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= PTR_ZERO;
            rom_en_q   <= 1'b0;
            rom_addr_q <= {ADDR_W{1'b0}};
            tag_v_q    <= {(RD_LAT+1){1'b0}};
            tag_id_q   <= {((RD_LAT+1)*NREQ){1'b0}};
            rd_valid_q <= {NREQ{1'b0}};
            rd_data_q  <= {DATA_W{1'b0}};
        end else begin
            ptr_q      <= ptr_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            tag_v_q    <= tag_v_d;
            tag_id_q   <= tag_id_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rom_en   = rom_en_q;
    assign rom_addr = rom_addr_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: NREQ=2 instance against a cycle model,
// plus an NREQ=3 instance for pointer wrap-around.
module tb_sprite_rom_arbiter;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 12;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst = 1'b1;
    logic                   frame_start = 1'b0;
    logic [NREQ-1:0]        req = 2'b11;
    logic [NREQ*ADDR_W-1:0] req_addr = 40'h0;
    logic [NREQ-1:0]        gnt, rd_valid;
    logic                   rom_en;
    logic [ADDR_W-1:0]      rom_addr;
    logic [DATA_W-1:0]      rom_data, rd_data;

    logic [2:0]             req3 = 3'b000;
    logic [3*ADDR_W-1:0]    req_addr3 = {20'hCCCCC, 20'hBBBBB, 20'hAAAAA};
    logic [2:0]             gnt3, rd_valid3;
    logic                   rom_en3;
    logic [ADDR_W-1:0]      rom_addr3;
    logic [DATA_W-1:0]      rd_data3;
    logic                   frame_start3 = 1'b0;
    logic [DATA_W-1:0]      rom_data3 = 12'h000;

    int n_vec = 0;
    int n_err = 0;

    sprite_rom_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .req(req), .req_addr(req_addr),
        .gnt(gnt), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    sprite_rom_arbiter #(.NREQ(3), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut3 (
        .clk(clk), .rst(rst), .frame_start(frame_start3), .req(req3), .req_addr(req_addr3),
        .gnt(gnt3), .rom_en(rom_en3), .rom_addr(rom_addr3), .rom_data(rom_data3),
        .rd_valid(rd_valid3), .rd_data(rd_data3)
    );

    // ROM contents: chosen so that address 00ABC holds F00.
    function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
        return a[11:0] ^ 12'h5BC ^ {a[19:12], 4'h0};
    endfunction

    logic [ADDR_W-1:0] apipe [RD_LAT];
    always @(posedge clk) begin
        apipe[0] <= rom_addr;
        for (int k = 1; k < RD_LAT; k++) apipe[k] <= apipe[k-1];
    end
    assign rom_data = rom_f(apipe[RD_LAT-1]);

    // Reference model: round-robin by modular scan, returns scheduled by absolute cycle.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    int                m_ptr = 0;
    int                edge_n = 0;
    int                m_g;
    logic [NREQ-1:0]   m_gnt;
    logic              m_en;
    logic [ADDR_W-1:0] m_addr;
    logic [NREQ-1:0]   m_rdv;
    logic [DATA_W-1:0] m_rdd;
    logic              s_v [8];
    int                s_id [8];
    logic [ADDR_W-1:0] s_a [8];

    assign m_g   = rst ? -1 : pick(req, m_ptr);
    assign m_gnt = (m_g < 0) ? 2'b00 : 2'(1 << m_g);

    always @(posedge clk) begin
        if (rst) begin
            m_ptr  <= 0;
            m_en   <= 1'b0;
            m_addr <= 20'h0;
            m_rdv  <= 2'b00;
            m_rdd  <= 12'h000;
            for (int i = 0; i < 8; i++) s_v[i] <= 1'b0;
        end else begin
            m_en <= (m_g >= 0);
            if (m_g >= 0) m_addr <= req_addr[m_g*ADDR_W +: ADDR_W];
            if (s_v[edge_n % 8]) begin
                m_rdv <= 2'(1 << s_id[edge_n % 8]);
                m_rdd <= rom_f(s_a[edge_n % 8]);
            end else begin
                m_rdv <= 2'b00;
            end
            s_v[edge_n % 8] <= 1'b0;
            if (m_g >= 0) begin
                s_v[(edge_n + RD_LAT + 1) % 8]  <= 1'b1;
                s_id[(edge_n + RD_LAT + 1) % 8] <= m_g;
                s_a[(edge_n + RD_LAT + 1) % 8]  <= req_addr[m_g*ADDR_W +: ADDR_W];
            end
            m_ptr <= frame_start ? 0 : ((m_g >= 0) ? (m_g + 1) % NREQ : m_ptr);
        end
        edge_n <= edge_n + 1;
    end

    wire [36:0] obs_s = {gnt, rom_en, rom_addr, rd_valid, rd_data};
    wire [36:0] exp_s = {m_gnt, m_en, m_addr, m_rdv, m_rdd};

    task automatic test_reset();
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if (gnt !== 2'b00) begin
            n_err++; $display("FAIL reset_gnt: got %b want 00", gnt);
        end
        n_vec++;
        if ({rom_en, rom_addr, rd_valid, rd_data} !== 35'h0) begin
            n_err++; $display("FAIL reset_regs: got en=%b addr=%h v=%b d=%h want all 0", rom_en, rom_addr, rd_valid, rd_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req = 2'b00;
    endtask

    task automatic test_single();
        req      = 2'b01;
        req_addr = {20'($urandom), 20'h00ABC};
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_err++; $display("FAIL single_model cyc %0d: got %h want %h", k, obs_s, exp_s);
            end
            if (k == 0) begin
                n_vec++;
                if (gnt !== 2'b01) begin n_err++; $display("FAIL single_gnt: got %b want 01", gnt); end
            end
            if (k == 1) begin
                n_vec++;
                if (rom_en !== 1'b1 || rom_addr !== 20'h00ABC) begin
                    n_err++; $display("FAIL single_issue: got en=%b addr=%h want 1 00abc", rom_en, rom_addr);
                end
            end
            if (k == 4) begin
                n_vec++;
                if (rd_valid !== 2'b01 || rd_data !== 12'hF00) begin
                    n_err++; $display("FAIL single_return: got v=%b d=%h want 01 f00", rd_valid, rd_data);
                end
            end
            if (k == 5) begin
                n_vec++;
                if (rd_valid !== 2'b00) begin n_err++; $display("FAIL single_oneshot: got %b want 00", rd_valid); end
            end
            @(posedge clk); #1;
            req = 2'b00;
        end
    endtask

    task automatic test_contention();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            req      = (k < 6) ? 2'b11 : 2'b00;
            req_addr = {20'($urandom), 20'($urandom)};
            @(negedge clk);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_err++; $display("FAIL contention_model cyc %0d: got %h want %h", k, obs_s, exp_s);
            end
            if (k < 6) begin
                n_vec++;
                if (gnt !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_err++; $display("FAIL contention_gnt cyc %0d: got %b", k, gnt);
                end
            end
            if (k >= 4 && k < 10) begin
                n_vec++;
                if (rd_valid !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_err++; $display("FAIL contention_rdv cyc %0d: got %b", k, rd_valid);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_frame_start();
        for (int k = 0; k < 8; k++) begin
            req         = (k == 0) ? 2'b01 : ((k < 3) ? 2'b11 : 2'b00);
            frame_start = (k == 1);
            req_addr    = {20'($urandom), 20'($urandom)};
            @(negedge clk);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_err++; $display("FAIL frame_model cyc %0d: got %h want %h", k, obs_s, exp_s);
            end
            if (k == 1 || k == 2) begin
                n_vec++;
                if (gnt !== ((k == 1) ? 2'b10 : 2'b01)) begin
                    n_err++; $display("FAIL frame_gnt cyc %0d: got %b", k, gnt);
                end
            end
            if (k == 5) begin
                n_vec++;
                if (rd_valid !== 2'b10) begin n_err++; $display("FAIL frame_inflight: got %b want 10", rd_valid); end
            end
            @(posedge clk); #1;
        end
        frame_start = 1'b0;
    endtask

    task automatic test_idle();
        logic [ADDR_W-1:0] held_addr;
        logic [DATA_W-1:0] held_data;
        held_addr = rom_addr;
        held_data = rd_data;
        req = 2'b00;
        for (int k = 0; k < 10; k++) begin
            req_addr = {20'($urandom), 20'($urandom)};
            @(negedge clk);
            n_vec++;
            if (rom_en !== 1'b0 || rom_addr !== held_addr || rd_data !== held_data || obs_s !== exp_s) begin
                n_err++; $display("FAIL idle_hold cyc %0d: got %h want %h", k, obs_s, exp_s);
            end
            @(posedge clk); #1;
        end
        req = 2'b11;
        @(negedge clk);
        n_vec++;
        if (gnt !== 2'b10) begin n_err++; $display("FAIL idle_ptr: got %b want 10", gnt); end
        @(posedge clk); #1;
        req = 2'b00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_err++; $display("FAIL idle_drain cyc %0d: got %h want %h", k, obs_s, exp_s);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 46; k++) begin
            req         = (k < 40) ? 2'($urandom) : 2'b00;
            frame_start = (k < 40) && ($urandom_range(0, 7) == 0);
            req_addr    = {20'($urandom), 20'($urandom)};
            @(negedge clk);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_err++; $display("FAIL random_model cyc %0d: got %h want %h", k, obs_s, exp_s);
            end
            @(posedge clk); #1;
        end
        frame_start = 1'b0;
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 3; k++) begin
            req      = 2'b11;
            rst      = (k == 2);
            req_addr = {20'($urandom), 20'($urandom)};
            @(negedge clk);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_err++; $display("FAIL midrst_model cyc %0d: got %h want %h", k, obs_s, exp_s);
            end
            if (k == 2) begin
                n_vec++;
                if (gnt !== 2'b00) begin n_err++; $display("FAIL midrst_gnt: got %b want 00", gnt); end
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        req = 2'b00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_vec++;
            if (rd_valid !== 2'b00 || obs_s !== exp_s) begin
                n_err++; $display("FAIL midrst_drop cyc %0d: got %h want %h", k, obs_s, exp_s);
            end
            if (k == 0) begin
                n_vec++;
                if (rom_en !== 1'b0 || rom_addr !== 20'h0 || rd_data !== 12'h000) begin
                    n_err++; $display("FAIL midrst_regs: got en=%b addr=%h d=%h want 0", rom_en, rom_addr, rd_data);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap3();
        logic [ADDR_W-1:0] want_addr;
        req3 = 3'b101;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            n_vec++;
            if (gnt3 !== ((k % 2 == 0) ? 3'b001 : 3'b100)) begin
                n_err++; $display("FAIL wrap3_gnt cyc %0d: got %b", k, gnt3);
            end
            if (k > 0) begin
                want_addr = ((k - 1) % 2 == 0) ? 20'hAAAAA : 20'hCCCCC;
                n_vec++;
                if (rom_en3 !== 1'b1 || rom_addr3 !== want_addr) begin
                    n_err++; $display("FAIL wrap3_addr cyc %0d: got en=%b addr=%h want 1 %h", k, rom_en3, rom_addr3, want_addr);
                end
            end
            @(posedge clk); #1;
        end
        req3 = 3'b000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_frame_start();
        test_idle();
        test_random();
        test_reset_midflight();
        test_wrap3();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
